fft4_stream: RTL and testbench

- Sample-serial, parametrised 4-point DFT engine with valid/ready streaming on both sides.
- Collects 4 complex samples, computes forward or inverse DFT exactly (trivial twiddles, adder-only), and drains 4 bins in order.
- Output scaling is selectable.
- Sits between the sample source and the spectral post-processing; successor to the fixed 16-bit parallel FFT4.

---
 rtl/fft4_stream.sv | 142 ++++++++++++++
 tb/tb_fft4_stream.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fft4_stream.sv
// fft4_stream: sample-serial 4-point DFT with valid/ready streams.
// Collects four complex samples, computes the forward or inverse DFT with
// adders only (twiddles are 1, -1, +j and -j), then drains the four bins in
// order while the collector fills the next frame.

// One output component lane: optional divide-by-4 (floor) after the butterfly.
module fft4_scale #(
  parameter int OW    = 18,
  parameter int SCALE = 0
) (
  input  logic signed [OW-1:0] din,
  output logic signed [OW-1:0] dout
);
  assign dout = (SCALE != 0) ? (din >>> 2) : din;
endmodule

module fft4_stream #(
  parameter int DW    = 16,
  parameter int SCALE = 0,
  parameter int OW    = DW + 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [2*DW-1:0] s_data,
  input  logic            s_last,
  input  logic            s_inv,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [2*OW-1:0] m_data,
  output logic [1:0]      m_index,
  output logic            m_last,
  output logic            frame_err
);

  // collector state
  logic [1:0]           wr_cnt;
  logic                 in_full;
  logic                 inv_q;
  logic [3:0][DW-1:0]   x_re, x_im;

  // output buffer
  logic [3:0][OW-1:0]   ob_re, ob_im;

  // butterfly results before/after scaling
  logic [3:0][OW-1:0]   raw_re, raw_im;
  logic [3:0][OW-1:0]   sc_re, sc_im;

  logic accept, xfer, beat;

  assign s_ready = !in_full;
  assign accept  = s_valid && s_ready;
  // Transfer only into an empty output buffer; a last-beat drain in the
  // same cycle defers the transfer by one cycle.
  assign xfer    = in_full && !m_valid;
  assign beat    = m_valid && m_ready;

  // Collect samples, detect framing errors, hand the frame off on transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt    <= '0;
      in_full   <= 1'b0;
      inv_q     <= 1'b0;
      frame_err <= 1'b0;
      x_re      <= '0;
      x_im      <= '0;
    end else begin
      frame_err <= 1'b0;
      if (xfer) in_full <= 1'b0;
      if (accept) begin
        if (s_last && (wr_cnt != 2'd3)) begin
          // early s_last: drop the partial frame and this sample
          wr_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          x_re[wr_cnt] <= s_data[DW-1:0];
          x_im[wr_cnt] <= s_data[2*DW-1:DW];
          if (wr_cnt == 2'd0) inv_q <= s_inv;
          if (wr_cnt == 2'd3) begin
            in_full   <= 1'b1;
            frame_err <= !s_last;   // missing s_last: flag it, still process
          end
          wr_cnt <= wr_cnt + 2'd1;  // wraps 3 -> 0
        end
      end
    end
  end

  // Radix-4 butterfly, everything widened to OW first so nothing overflows.
  logic signed [OW-1:0] xr [4];
  logic signed [OW-1:0] xi [4];
  logic signed [OW-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
  logic signed [OW-1:0] f1_re, f1_im, f3_re, f3_im;

  // Combinational DFT of the collected frame.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      xr[i] = {{(OW-DW){x_re[i][DW-1]}}, x_re[i]};
      xi[i] = {{(OW-DW){x_im[i][DW-1]}}, x_im[i]};
    end
    a_re = xr[0] + xr[2];  a_im = xi[0] + xi[2];
    b_re = xr[0] - xr[2];  b_im = xi[0] - xi[2];
    c_re = xr[1] + xr[3];  c_im = xi[1] + xi[3];
    d_re = xr[1] - xr[3];  d_im = xi[1] - xi[3];
    // forward: X1 = b - j*d, X3 = b + j*d
    f1_re = b_re + d_im;   f1_im = b_im - d_re;
    f3_re = b_re - d_im;   f3_im = b_im + d_re;
    raw_re[0] = a_re + c_re;  raw_im[0] = a_im + c_im;
    raw_re[2] = a_re - c_re;  raw_im[2] = a_im - c_im;
    // inverse transform just swaps bins 1 and 3
    raw_re[1] = inv_q ? f3_re : f1_re;  raw_im[1] = inv_q ? f3_im : f1_im;
    raw_re[3] = inv_q ? f1_re : f3_re;  raw_im[3] = inv_q ? f1_im : f3_im;
  end

  for (genvar g = 0; g < 4; g++) begin : g_bin
    fft4_scale #(.OW(OW), .SCALE(SCALE)) u_re (.din(raw_re[g]), .dout(sc_re[g]));
    fft4_scale #(.OW(OW), .SCALE(SCALE)) u_im (.din(raw_im[g]), .dout(sc_im[g]));
  end

  // Load the output buffer on transfer, then step through the bins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_index <= '0;
      ob_re   <= '0;
      ob_im   <= '0;
    end else if (xfer) begin
      ob_re   <= sc_re;
      ob_im   <= sc_im;
      m_valid <= 1'b1;
      m_index <= '0;
    end else if (beat) begin
      if (m_index == 2'd3) m_valid <= 1'b0;
      m_index <= m_index + 2'd1;
    end
  end

  assign m_data = {ob_im[m_index], ob_re[m_index]};
  assign m_last = m_valid && (m_index == 2'd3);

endmodule

// File: tb/tb_fft4_stream.sv
// Directed bench for fft4_stream: vector table of frames with hand-computed
// bins, plus sequences for latency, backpressure, framing and async reset.
// A second instance built with SCALE=1 shares all inputs and is checked
// against the same expectations divided by 4 (floor).
module tb_fft4_stream;
  localparam int DW = 16;
  localparam int OW = DW + 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0, s_inv = 1'b0, m_ready = 1'b0;
  logic [2*DW-1:0] s_data = '0;
  logic s_ready, m_valid, m_last, frame_err;
  logic [1:0] m_index;
  logic [2*OW-1:0] m_data;
  logic s_ready2, m_valid2, m_last2, frame_err2;
  logic [1:0] m_index2;
  logic [2*OW-1:0] m_data2;

  int total = 0;
  int bad = 0;

  fft4_stream #(.DW(DW), .SCALE(0)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_inv(s_inv), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_index(m_index), .m_last(m_last), .frame_err(frame_err));

  fft4_stream #(.DW(DW), .SCALE(1)) dut_s (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .s_last(s_last), .s_inv(s_inv), .m_valid(m_valid2), .m_ready(m_ready),
    .m_data(m_data2), .m_index(m_index2), .m_last(m_last2), .frame_err(frame_err2));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] xr;
    logic [3:0][31:0] xi;
    logic             inv;
    logic [3:0][31:0] er;
    logic [3:0][31:0] ei;
  } vec_t;
  vec_t v [7];

  function automatic logic [3:0][31:0] pk(int e0, int e1, int e2, int e3);
    logic [3:0][31:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  function automatic int sre(logic [2*OW-1:0] d);
    logic signed [OW-1:0] t;
    t = d[OW-1:0];
    return int'(t);
  endfunction

  function automatic int sim(logic [2*OW-1:0] d);
    logic signed [OW-1:0] t;
    t = d[2*OW-1:OW];
    return int'(t);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Present one sample and hold it until accepted (bounded wait).
  task automatic put(int r, int i, bit last, bit inv);
    int n;
    @(negedge clk);
    s_valid = 1'b1; s_data = {16'(i), 16'(r)}; s_last = last; s_inv = inv;
    n = 0;
    while (!s_ready && n < 100) begin @(negedge clk); n++; end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL put_timeout: s_ready=0, expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_frame(int id, bit last3);
    for (int j = 0; j < 4; j++)
      put(int'(v[id].xr[j]), int'(v[id].xi[j]), (j == 3) && last3, v[id].inv);
  endtask

  // Accept one output bin and check it on both instances.
  task automatic get_bin(string nm, int k, int er, int ei);
    int n;
    @(negedge clk);
    m_ready = 1'b1;
    n = 0;
    while (!m_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, int'(m_valid), 1);
    chk({nm, "_index"}, int'(m_index), k);
    chk({nm, "_last"}, int'(m_last), int'(k == 3));
    chk({nm, "_re"}, sre(m_data), er);
    chk({nm, "_im"}, sim(m_data), ei);
    chk({nm, "_s_index"}, int'(m_index2), k);
    chk({nm, "_s_re"}, sre(m_data2), er >>> 2);
    chk({nm, "_s_im"}, sim(m_data2), ei >>> 2);
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v[0] = '{xr: pk(1,0,0,0),   xi: pk(0,0,0,0),   inv: 1'b0, er: pk(1,1,1,1),        ei: pk(0,0,0,0)};
    v[1] = '{xr: pk(100,100,100,100), xi: pk(0,0,0,0), inv: 1'b0, er: pk(400,0,0,0), ei: pk(0,0,0,0)};
    v[2] = '{xr: pk(0,1,0,-1),  xi: pk(0,0,0,0),   inv: 1'b0, er: pk(0,0,0,0),        ei: pk(0,-2,0,2)};
    v[3] = '{xr: pk(0,1,0,-1),  xi: pk(0,0,0,0),   inv: 1'b1, er: pk(0,0,0,0),        ei: pk(0,2,0,-2)};
    v[4] = '{xr: pk(32767,32767,32767,32767), xi: pk(0,0,0,0), inv: 1'b0, er: pk(131068,0,0,0), ei: pk(0,0,0,0)};
    v[5] = '{xr: pk(-32768,-32768,-32768,-32768), xi: pk(0,0,0,0), inv: 1'b0, er: pk(-131072,0,0,0), ei: pk(0,0,0,0)};
    v[6] = '{xr: pk(3,-5,7,1),  xi: pk(4,2,-1,-6), inv: 1'b0, er: pk(6,4,14,-12),     ei: pk(-1,11,7,-1)};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_index", int'(m_index), 0);
    chk("rst_m_last", int'(m_last), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_m_data", sre(m_data) | sim(m_data), 0);
    @(negedge clk);
    rstn = 1'b1;

    // table: each frame, with transfer latency checked around the 4th accept
    for (int id = 0; id < 7; id++) begin
      send_frame(id, 1'b1);
      chk($sformatf("v%0d_full_s_ready", id), int'(s_ready), 0);
      chk($sformatf("v%0d_full_m_valid", id), int'(m_valid), 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_xfer_m_valid", id), int'(m_valid), 1);
      chk($sformatf("v%0d_xfer_s_ready", id), int'(s_ready), 1);
      for (int k = 0; k < 4; k++)
        get_bin($sformatf("v%0d_b%0d", id, k), k, int'(v[id].er[k]), int'(v[id].ei[k]));
    end
    @(negedge clk);
    chk("idle_m_valid", int'(m_valid), 0);

    // backpressure: stall on bin 1 while a second frame fills the collector
    send_frame(6, 1'b1);
    get_bin("bp_b0", 0, 6, -1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_index", int'(m_index), 1);
      chk("bp_hold_re", sre(m_data), 4);
      chk("bp_hold_im", sim(m_data), 11);
    end
    send_frame(2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_full_s_ready", int'(s_ready), 0);
      chk("bp_full_index", int'(m_index), 1);
    end
    get_bin("bp_b1", 1, 4, 11);
    get_bin("bp_b2", 2, 14, 7);
    get_bin("bp_b3", 3, -12, -1);
    for (int k = 0; k < 4; k++)
      get_bin($sformatf("bp2_b%0d", k), k, int'(v[2].er[k]), int'(v[2].ei[k]));

    // framing: early s_last drops the partial frame
    put(5, 0, 1'b0, 1'b0);
    put(7, 0, 1'b1, 1'b0);
    chk("fe_early_pulse", int'(frame_err), 1);
    @(posedge clk); #1;
    chk("fe_early_clear", int'(frame_err), 0);
    repeat (4) @(negedge clk);
    chk("fe_early_no_out", int'(m_valid), 0);
    send_frame(1, 1'b1);
    for (int k = 0; k < 4; k++)
      get_bin($sformatf("fe_dc_b%0d", k), k, int'(v[1].er[k]), int'(v[1].ei[k]));

    // framing: missing s_last on 4th sample flags but still processes
    send_frame(2, 1'b0);
    chk("fe_late_pulse", int'(frame_err), 1);
    for (int k = 0; k < 4; k++)
      get_bin($sformatf("fe_late_b%0d", k), k, int'(v[2].er[k]), int'(v[2].ei[k]));

    // async reset while bin 1 is pending
    send_frame(0, 1'b1);
    get_bin("ar_b0", 0, 1, 0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("ar_m_valid", int'(m_valid), 0);
    chk("ar_s_ready", int'(s_ready), 1);
    chk("ar_m_index", int'(m_index), 0);
    chk("ar_m_data", sre(m_data) | sim(m_data), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("ar_no_stale", int'(m_valid), 0);
    send_frame(6, 1'b1);
    for (int k = 0; k < 4; k++)
      get_bin($sformatf("ar_b%0d", k), k, int'(v[6].er[k]), int'(v[6].ei[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
